// File: rtl/servo_pkg.sv
// Shared definitions for the servo output stage: rail debounce states and
// the bit positions of the two railed flags.
package servo_pkg;

    typedef enum logic [1:0] {
        RAIL_CLEAR    = 2'd0,
        RAIL_COUNTING = 2'd1,
        RAIL_RAILED   = 2'd2
    } rail_state_t;

    localparam int unsigned RAIL_LO = 0;
    localparam int unsigned RAIL_HI = 1;

endpackage

// File: rtl/rail_debounce.sv
// Debounces one side's clamp flag: asserts railed after RAIL_COUNT consecutive
// clamped ticks, drops immediately on the first unclamped tick or when disabled.
module rail_debounce
    import servo_pkg::*;
#(
    parameter int unsigned RAIL_COUNT = 4'h8
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic tick,
    input  logic flag,
    output logic railed
);

    localparam int unsigned CNT_W = (RAIL_COUNT < 2) ? 1 : $clog2(RAIL_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAIL_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rail_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RAIL_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!enable) begin
            state_nxt = RAIL_CLEAR;
            cnt_nxt   = '0;
        end else if (tick) begin
            if (!flag) begin
                state_nxt = RAIL_CLEAR;
                cnt_nxt   = '0;
            end else begin
                case (state)
                    RAIL_CLEAR: begin
                        cnt_nxt   = CNT_ONE;
                        state_nxt = (RAIL_COUNT <= 1) ? RAIL_RAILED : RAIL_COUNTING;
                    end
                    RAIL_COUNTING: begin
                        cnt_nxt = cnt + CNT_ONE;
                        if (cnt_nxt >= CNT_LAST)
                            state_nxt = RAIL_RAILED;
                    end
                    RAIL_RAILED: state_nxt = RAIL_RAILED;
                    default: begin
                        state_nxt = RAIL_CLEAR;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

    assign railed = (state == RAIL_RAILED);

endmodule

// File: rtl/servo_output_limiter.sv
// Output conditioning between loop filter and DAC: offset, clamp to rails,
// per-update slew limit, and debounced railed flags for anti-windup.
module servo_output_limiter
    import servo_pkg::*;
#(
    parameter int unsigned SIGNAL_SIZE = 16,
    parameter int unsigned SLEW_SIZE   = 16,
    parameter int unsigned RAIL_COUNT  = 4'h8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          on_in,
    input  logic                          update_in,
    input  logic signed [SIGNAL_SIZE-1:0] signal_in,
    input  logic signed [SIGNAL_SIZE-1:0] offset_in,
    input  logic signed [SIGNAL_SIZE-1:0] min_in,
    input  logic signed [SIGNAL_SIZE-1:0] max_in,
    input  logic        [SLEW_SIZE-1:0]   slew_in,
    output logic        [1:0]             railed_out,
    output logic signed [SIGNAL_SIZE-1:0] signal_out,
    output logic                          valid_out
);

    localparam int unsigned SW = SIGNAL_SIZE + 1;
    // Slew arithmetic width: wide enough for |target - out| and the full slew range, plus sign.
    localparam int unsigned DW = ((SW > SLEW_SIZE) ? SW : SLEW_SIZE) + 1;

    logic signed [SW-1:0]          sum_d, sum_q, lo_x, hi_x;
    logic signed [SIGNAL_SIZE-1:0] hi, target_d, target_q, out_d;
    logic                          clamp_lo_d, clamp_hi_d, clamp_lo_q, clamp_hi_q;
    logic signed [DW-1:0]          diff, mag, slew_x, stepped;

    always_comb begin
        sum_d = on_in ? (SW'(signal_in) + SW'(offset_in)) : SW'(offset_in);

        hi         = (max_in > min_in) ? max_in : min_in;
        lo_x       = SW'(min_in);
        hi_x       = SW'(hi);
        clamp_lo_d = (sum_q < lo_x);
        clamp_hi_d = (sum_q > hi_x);
        target_d   = clamp_lo_d ? min_in :
                     clamp_hi_d ? hi     : $signed(sum_q[SIGNAL_SIZE-1:0]);

        diff    = DW'(target_q) - DW'(signal_out);
        mag     = (diff < 0) ? -diff : diff;
        slew_x  = $signed(DW'(slew_in));
        stepped = (diff < 0) ? (DW'(signal_out) - slew_x) : (DW'(signal_out) + slew_x);
        if ((slew_in == '0) || (mag <= slew_x))
            out_d = target_q;
        else
            out_d = $signed(stepped[SIGNAL_SIZE-1:0]);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sum_q      <= '0;
            target_q   <= '0;
            clamp_lo_q <= 1'b0;
            clamp_hi_q <= 1'b0;
            signal_out <= '0;
            valid_out  <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            target_q   <= target_d;
            clamp_lo_q <= clamp_lo_d;
            clamp_hi_q <= clamp_hi_d;
            valid_out  <= update_in;
            if (update_in)
                signal_out <= out_d;
        end
    end

    rail_debounce #(.RAIL_COUNT(RAIL_COUNT)) u_rail_lo (
        .clk    (clk_in),
        .rst    (rst_in),
        .enable (on_in),
        .tick   (update_in),
        .flag   (clamp_lo_q),
        .railed (railed_out[RAIL_LO])
    );

    rail_debounce #(.RAIL_COUNT(RAIL_COUNT)) u_rail_hi (
        .clk    (clk_in),
        .rst    (rst_in),
        .enable (on_in),
        .tick   (update_in),
        .flag   (clamp_hi_q),
        .railed (railed_out[RAIL_HI])
    );

endmodule
